// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: icodes, ALU/condition function codes,
// one-hot status values, bubble contents and the branch/cmov condition evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [3:0] BUBBLE_STAT  = STAT_AOK;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic       BUBBLE_CND   = 1'b0;
  localparam logic [3:0] BUBBLE_DEST  = REG_NONE;

  // CC is packed {ZF, SF, OF}.
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// E/M pipeline bundle seen by the execute stage; the stage is the slave, the surrounding
// pipeline (decode/memory/writeback control) is the master.
interface execute_stage_if #(parameter int WORD_W = 64);
  logic [3:0]        E_stat;
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [WORD_W-1:0] E_valC;
  logic [WORD_W-1:0] E_valA;
  logic [WORD_W-1:0] E_valB;
  logic [3:0]        E_destE;
  logic [3:0]        E_destM;
  logic [3:0]        m_stat;
  logic [3:0]        W_stat;
  logic              M_bubble;
  logic [WORD_W-1:0] e_valE;
  logic [3:0]        e_destE;
  logic              e_Cnd;
  logic [3:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [WORD_W-1:0] M_valE;
  logic [WORD_W-1:0] M_valA;
  logic [3:0]        M_destE;
  logic [3:0]        M_destM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_destE, E_destM,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_destE, e_Cnd,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_destE, E_destM,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_destE, e_Cnd,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM
  );
endinterface

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: computes aluB op aluA and the ZF/SF/OF flags of that result.
module y86_alu
  import y86_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic [WORD_W-1:0] aluA,
  input  logic [WORD_W-1:0] aluB,
  input  alu_op_t           op,
  output logic [WORD_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = aluB + aluA;
        of     = (aluA[WORD_W-1] == aluB[WORD_W-1]) && (result[WORD_W-1] != aluB[WORD_W-1]);
      end
      ALU_SUB: begin
        result = aluB - aluA;
        of     = (aluA[WORD_W-1] != aluB[WORD_W-1]) && (result[WORD_W-1] != aluB[WORD_W-1]);
      end
      ALU_AND: result = aluB & aluA;
      ALU_XOR: result = aluB ^ aluA;
      default: result = aluB + aluA;
    endcase
    zf = (result == '0);
    sf = result[WORD_W-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, jXX/cmovXX evaluation and the M register.
// Optional EXECUTE_PERF_CNT_EN adds retired-instruction and taken-branch counters.
module execute_stage
  import y86_pkg::*;
#(
  parameter int WORD_W     = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  execute_stage_if.slave   bus
`ifdef EXECUTE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_insn,
  output logic [31:0]      perf_taken
`endif
);

  logic [WORD_W-1:0] alu_a, alu_b, alu_result;
  logic              alu_zf, alu_sf, alu_of;
  alu_op_t           alu_op;
  logic [2:0]        cc_reg;
  logic              cc_update;
  logic              cnd;
  logic [3:0]        dest_e;

  logic [3:0]        m_stat_reg, m_icode_reg, m_dest_e_reg, m_dest_m_reg;
  logic              m_cnd_reg;
  logic [WORD_W-1:0] m_val_e_reg, m_val_a_reg;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (bus.E_icode)
      I_CMOVXX, I_OPQ:            alu_a = bus.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
      I_CALL, I_PUSHQ:            alu_a = '0 - WORD_W'(STACK_STEP);
      I_RET, I_POPQ:              alu_a = WORD_W'(STACK_STEP);
      default:                    alu_a = '0;
    endcase
    case (bus.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.E_valB;
      default:                                                   alu_b = '0;
    endcase
  end

  // Undefined OPq function codes fall back to add rather than being flagged here.
  assign alu_op = (bus.E_icode == I_OPQ && bus.E_ifun[3:2] == 2'b00)
                  ? alu_op_t'(bus.E_ifun[1:0]) : ALU_ADD;

  y86_alu #(.WORD_W(WORD_W)) u_alu (
    .aluA   (alu_a),
    .aluB   (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Any non-AOK status in E, M or W freezes CC so a faulting instruction leaves no trace.
  assign cc_update = (bus.E_icode == I_OPQ) && (bus.E_stat == STAT_AOK)
                     && (bus.m_stat == STAT_AOK) && (bus.W_stat == STAT_AOK);

  assign cnd    = (bus.E_icode == I_CMOVXX || bus.E_icode == I_JXX)
                  ? cond_eval(bus.E_ifun, cc_reg) : 1'b0;
  assign dest_e = (bus.E_icode == I_CMOVXX && !cnd) ? REG_NONE : bus.E_destE;

  assign bus.e_valE  = alu_result;
  assign bus.e_destE = dest_e;
  assign bus.e_Cnd   = cnd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_reg <= 3'b100;
    end else if (cc_update) begin
      cc_reg <= {alu_zf, alu_sf, alu_of};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.M_bubble) begin
      m_stat_reg   <= BUBBLE_STAT;
      m_icode_reg  <= BUBBLE_ICODE;
      m_cnd_reg    <= BUBBLE_CND;
      m_val_e_reg  <= '0;
      m_val_a_reg  <= '0;
      m_dest_e_reg <= BUBBLE_DEST;
      m_dest_m_reg <= BUBBLE_DEST;
    end else begin
      m_stat_reg   <= bus.E_stat;
      m_icode_reg  <= bus.E_icode;
      m_cnd_reg    <= cnd;
      m_val_e_reg  <= alu_result;
      m_val_a_reg  <= bus.E_valA;
      m_dest_e_reg <= dest_e;
      m_dest_m_reg <= bus.E_destM;
    end
  end

  assign bus.M_stat  = m_stat_reg;
  assign bus.M_icode = m_icode_reg;
  assign bus.M_Cnd   = m_cnd_reg;
  assign bus.M_valE  = m_val_e_reg;
  assign bus.M_valA  = m_val_a_reg;
  assign bus.M_destE = m_dest_e_reg;
  assign bus.M_destM = m_dest_m_reg;

`ifdef EXECUTE_PERF_CNT_EN
  logic [31:0] perf_insn_reg, perf_taken_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_insn_reg  <= '0;
      perf_taken_reg <= '0;
    end else if (!bus.M_bubble) begin
      if (bus.E_icode != I_NOP)
        perf_insn_reg <= perf_insn_reg + 32'd1;
      if (bus.E_icode == I_JXX && cnd)
        perf_taken_reg <= perf_taken_reg + 32'd1;
    end
  end

  assign perf_insn  = perf_insn_reg;
  assign perf_taken = perf_taken_reg;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed table-driven bench for execute_stage: combinational e_* checked mid-cycle,
// registered M_* checked just after the edge, plus reset/mid-stream-reset sequences.
module tb_execute_stage;

  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;
  localparam logic [3:0] ADR = 4'b0010;
  localparam logic [3:0] INS = 4'b0001;
  localparam logic [3:0] NR  = 4'hF;

  typedef struct {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  destE;
    logic [3:0]  destM;
    logic [3:0]  mst;
    logic [3:0]  wst;
    logic        bub;
    logic [63:0] x_valE;
    logic        x_cnd;
    logic [3:0]  x_destE;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  execute_stage_if #(.WORD_W(64)) bus ();

`ifdef EXECUTE_PERF_CNT_EN
  logic [31:0] perf_insn, perf_taken;
  execute_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave),
                     .perf_insn(perf_insn), .perf_taken(perf_taken));
`else
  execute_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] stat, icode, ifun,
                              input logic [63:0] valA, valB, valC,
                              input logic [3:0] destE, destM, mst, wst,
                              input logic bub,
                              input logic [63:0] x_valE, input logic x_cnd,
                              input logic [3:0] x_destE);
    vec_t v;
    v.stat = stat; v.icode = icode; v.ifun = ifun;
    v.valA = valA; v.valB = valB; v.valC = valC;
    v.destE = destE; v.destM = destM; v.mst = mst; v.wst = wst; v.bub = bub;
    v.x_valE = x_valE; v.x_cnd = x_cnd; v.x_destE = x_destE;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.E_stat = v.stat; bus.E_icode = v.icode; bus.E_ifun = v.ifun;
    bus.E_valA = v.valA; bus.E_valB = v.valB; bus.E_valC = v.valC;
    bus.E_destE = v.destE; bus.E_destM = v.destM;
    bus.m_stat = v.mst; bus.W_stat = v.wst; bus.M_bubble = v.bub;
  endtask

  task automatic chk_m_bubble(input string tag);
    chk({tag, " M_stat"},  64'(bus.M_stat),  64'(AOK));
    chk({tag, " M_icode"}, 64'(bus.M_icode), 64'h1);
    chk({tag, " M_Cnd"},   64'(bus.M_Cnd),   64'h0);
    chk({tag, " M_valE"},  bus.M_valE,       64'h0);
    chk({tag, " M_valA"},  bus.M_valA,       64'h0);
    chk({tag, " M_destE"}, 64'(bus.M_destE), 64'(NR));
    chk({tag, " M_destM"}, 64'(bus.M_destM), 64'(NR));
  endtask

  initial begin
    int exp_insn = 0;
    int exp_taken = 0;
    vec_t v;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;

    // CC sequence after reset {ZF,SF,OF}: 100 -> 010 (subq) -> 011 (add ovf) -> 100 (3-3)
    vecs.push_back(mk(AOK, 4'h7, 4'h3, 0, 0, 64'h40, NR, NR, AOK, AOK, 0, 0, 1, NR));        // je after reset
    vecs.push_back(mk(AOK, 4'h6, 4'h1, 5, 3, 0, 4'h3, NR, AOK, AOK, 0, M2, 0, 4'h3));       // subq 3-5
    vecs.push_back(mk(AOK, 4'h7, 4'h2, 64'h1234, 0, 64'h80, NR, NR, AOK, AOK, 0, 0, 1, NR)); // jl taken
    vecs.push_back(mk(AOK, 4'h7, 4'h6, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));            // jg not
    vecs.push_back(mk(AOK, 4'h6, 4'h0, MAXP, MAXP, 0, 4'h1, NR, AOK, AOK, 0, M2, 0, 4'h1)); // addq ovf
    vecs.push_back(mk(AOK, 4'h7, 4'h5, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 1, NR));            // jge: SF^OF=0
    vecs.push_back(mk(AOK, 4'h7, 4'h2, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));            // jl not
    vecs.push_back(mk(AOK, 4'h6, 4'h1, 3, 3, 0, 4'h4, NR, AOK, AOK, 0, 0, 0, 4'h4));        // subq 3-3
    vecs.push_back(mk(AOK, 4'h2, 4'h1, 64'hAA, 9, 0, 4'h5, NR, AOK, AOK, 0, 64'hAA, 1, 4'h5)); // cmovle
    vecs.push_back(mk(AOK, 4'h2, 4'h6, 64'hBB, 9, 0, 4'h5, NR, AOK, AOK, 0, 64'hBB, 0, NR));   // cmovg
    vecs.push_back(mk(AOK, 4'hA, 4'h0, 64'h55, 200, 0, 4'h4, NR, AOK, AOK, 0, 192, 0, 4'h4));  // pushq
    vecs.push_back(mk(AOK, 4'hB, 4'h0, 64'h77, 192, 0, 4'h4, 4'h6, AOK, AOK, 0, 200, 0, 4'h4)); // popq
    vecs.push_back(mk(AOK, 4'h8, 4'h0, 64'h1000, 200, 64'h2000, 4'h4, NR, AOK, AOK, 0, 192, 0, 4'h4)); // call
    vecs.push_back(mk(AOK, 4'h9, 4'h0, 64'h300, 192, 0, 4'h4, NR, AOK, AOK, 0, 200, 0, 4'h4));   // ret
    vecs.push_back(mk(AOK, 4'h3, 4'h0, 0, 999, 64'h42, 4'h2, NR, AOK, AOK, 0, 64'h42, 0, 4'h2)); // irmovq
    vecs.push_back(mk(AOK, 4'h5, 4'h0, 0, 64'h100, 64'h10, NR, 4'h3, AOK, AOK, 0, 64'h110, 0, NR)); // mrmovq
    vecs.push_back(mk(AOK, 4'h4, 4'h0, 5, 64'h100, 8, NR, NR, AOK, AOK, 0, 64'h108, 0, NR));      // rmmovq
    vecs.push_back(mk(AOK, 4'h6, 4'h2, 64'hF0F0, 64'hFF00, 0, 4'h1, NR, AOK, AOK, 0, 64'hF000, 0, 4'h1)); // andq -> CC 000
    vecs.push_back(mk(AOK, 4'h7, 4'h3, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));            // je not
    vecs.push_back(mk(AOK, 4'h6, 4'h3, 5, 5, 0, 4'h1, NR, ADR, AOK, 0, 0, 0, 4'h1));        // xorq, m ADR: frozen
    vecs.push_back(mk(AOK, 4'h7, 4'h3, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));
    vecs.push_back(mk(HLT, 4'h6, 4'h3, 9, 9, 0, 4'h1, NR, AOK, AOK, 0, 0, 0, 4'h1));        // E HLT: frozen
    vecs.push_back(mk(AOK, 4'h7, 4'h3, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));
    vecs.push_back(mk(AOK, 4'h6, 4'h3, 3, 3, 0, 4'h1, NR, AOK, INS, 0, 0, 0, 4'h1));        // W INS: frozen
    vecs.push_back(mk(AOK, 4'h7, 4'h3, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));
    vecs.push_back(mk(AOK, 4'h6, 4'h3, 6, 6, 0, 4'h7, NR, AOK, AOK, 1, 0, 0, 4'h7));        // bubble + xorq: CC 100
    vecs.push_back(mk(AOK, 4'h7, 4'h3, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 1, NR));            // je taken
    vecs.push_back(mk(AOK, 4'h7, 4'h4, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));            // jne not
    vecs.push_back(mk(AOK, 4'h6, 4'h7, 2, 3, 0, 4'h1, NR, AOK, AOK, 0, 5, 0, 4'h1));        // OPq ifun 7 -> add
    vecs.push_back(mk(AOK, 4'h7, 4'h0, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 1, NR));            // jmp
    vecs.push_back(mk(AOK, 4'h7, 4'h8, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));            // bad cond
    vecs.push_back(mk(AOK, 4'h1, 4'h0, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));            // nop
    vecs.push_back(mk(AOK, 4'h0, 4'h0, 0, 5, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));            // halt

    // Reset: two cycles low with an idle E register.
    drive(mk(AOK, 4'h1, 4'h0, 0, 0, 0, NR, NR, AOK, AOK, 0, 0, 0, NR));
    repeat (2) @(posedge clk);
    #1;
    chk_m_bubble("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      @(negedge clk);
      chk($sformatf("v%0d e_valE", i),  bus.e_valE,         v.x_valE);
      chk($sformatf("v%0d e_Cnd", i),   64'(bus.e_Cnd),     64'(v.x_cnd));
      chk($sformatf("v%0d e_destE", i), 64'(bus.e_destE),   64'(v.x_destE));
      @(posedge clk);
      #1;
      if (v.bub) begin
        chk_m_bubble($sformatf("v%0d", i));
      end else begin
        if (v.icode != 4'h1) exp_insn++;
        if (v.icode == 4'h7 && v.x_cnd) exp_taken++;
        chk($sformatf("v%0d M_stat", i),  64'(bus.M_stat),  64'(v.stat));
        chk($sformatf("v%0d M_icode", i), 64'(bus.M_icode), 64'(v.icode));
        chk($sformatf("v%0d M_Cnd", i),   64'(bus.M_Cnd),   64'(v.x_cnd));
        chk($sformatf("v%0d M_valE", i),  bus.M_valE,       v.x_valE);
        chk($sformatf("v%0d M_valA", i),  bus.M_valA,       v.valA);
        chk($sformatf("v%0d M_destE", i), 64'(bus.M_destE), 64'(v.x_destE));
        chk($sformatf("v%0d M_destM", i), 64'(bus.M_destM), 64'(v.destM));
      end
    end

`ifdef EXECUTE_PERF_CNT_EN
    chk("perf_insn",  64'(perf_insn),  64'(exp_insn));
    chk("perf_taken", 64'(perf_taken), 64'(exp_taken));
`endif

    // Mid-stream reset: CC is 000 (from the ifun-7 add); a je in flight is discarded
    // and CC returns to ZF=1.
    drive(mk(AOK, 4'h7, 4'h3, 64'h99, 0, 64'h500, NR, NR, AOK, AOK, 0, 0, 0, NR));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst e_Cnd before", 64'(bus.e_Cnd), 64'h0);
    @(posedge clk);
    #1;
    chk_m_bubble("midrst");
`ifdef EXECUTE_PERF_CNT_EN
    chk("midrst perf_insn",  64'(perf_insn),  64'h0);
    chk("midrst perf_taken", 64'(perf_taken), 64'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst e_Cnd after", 64'(bus.e_Cnd), 64'h1);
    @(posedge clk);
    #1;
    chk("midrst M_icode", 64'(bus.M_icode), 64'h7);
    chk("midrst M_Cnd",   64'(bus.M_Cnd),   64'h1);
    chk("midrst M_valA",  bus.M_valA,       64'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
